icallccnn_sequencer: RTL
========================

# icallccnn_sequencer

Execution sequencer for the Z80 `CALL cc,nn` group. It consumes the one-hot `P2_Set_ICALLccnn_k_0` start strobes from the opcode decoder and evaluates condition `cc` against the flag register. It fetches the 16-bit operand, and on a taken condition pushes the return address and redirects PC. It drives the shared memory request handshake and reports PC/SP updates to the register file.

## Interface
Parameters:
- none; widths are fixed by the Z80 architecture (16-bit address, 8-bit data).

Ports:
- `CLK` input 1: single system clock; all state changes on rising edge.
- `notReset` input 1: asynchronous, active-low reset.
- `P2_Set_ICALLccnn_k_0` (k = 0..7) input 1 each: one-cycle start strobe; k selects cc = NZ, Z, NC, C, PO, PE, P, M.
- `flags` input 8: F register; S = bit 7, Z = bit 6, P/V = bit 2, C = bit 0.
- `pc_in` input 16: address of operand low byte at the start cycle.
- `sp_in` input 16: current SP at the start cycle.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` output 16: access address.
- `mem_wdata` output 8: write data.
- `mem_rdata` input 8: read data; sampled on the ack cycle.
- `mem_ack` input 1: completes the current access; ignored while `mem_req` is low.
- `busy` output 1: high in every non-IDLE state.
- `pc_load` output 1: one-cycle pulse; register file loads `pc_next`.
- `pc_next` output 16: new PC value.
- `sp_load` output 1: one-cycle pulse; register file loads `sp_next`.
- `sp_next` output 16: new SP value.
- `done` output 1: one-cycle completion pulse.
- `start_err` output 1: one-cycle pulse when a start strobe is rejected.

## Operation
- States: IDLE, RD_LO, RD_HI, EVAL, WR_HI, WR_LO, FINISH.
- IDLE, exactly one strobe high: latch `pc_in`, `sp_in` and the condition result, then go to RD_LO.
- IDLE, more than one strobe high: stay in IDLE and pulse `start_err`.
- Strobes while `busy` is high: ignored silently; no `start_err`.
- Condition true when: NZ = !Z, Z = Z, NC = !C, C = C, PO = !PV, PE = PV, P = !S, M = S. Flags are sampled only in the start cycle.
- RD_LO: read at PC; on ack latch nn[7:0] and go to RD_HI.
- RD_HI: read at PC+1; on ack latch nn[15:8]. Go to EVAL if the condition is true, otherwise go to FINISH.
- EVAL: one internal cycle with `mem_req` low; then go to WR_HI.
- WR_HI: write RET[15:8] to SP-1; on ack go to WR_LO. RET = PC+2.
- WR_LO: write RET[7:0] to SP-2; on ack go to FINISH.
- FINISH: pulse `done` and `pc_load`, then return to IDLE.
  - Not taken: `pc_next` = RET, `sp_load` = 0.
  - Taken: `pc_next` = nn, `sp_next` = SP-2, `sp_load` = 1.
- Arithmetic is modulo 2^16.
  - PC = 0xFFFF reads 0xFFFF then 0x0000; RET = 0x0001.
  - SP = 0x0000 writes 0xFFFF then 0xFFFE; `sp_next` = 0xFFFE.
  - SP = 0x0001 writes 0x0000 then 0xFFFF.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and held stable until the ack cycle.
- Wait states: any number of cycles with `mem_ack` low; the state holds.

## Timing
- Reset: every output is 0 and the state is IDLE. Asserting reset mid-operation aborts immediately.
  - No further memory access is issued.
  - No `pc_load`, `sp_load` or `done` occurs.
  - A write already presented with `mem_req` is dropped.
- Start strobe at cycle T0; `mem_req` rises at T1.
- Not taken, zero wait states: RD_LO at T1, RD_HI at T2, FINISH at T3. `done` at T3; back in IDLE at T4.
- Taken, zero wait states: RD_LO T1, RD_HI T2, EVAL T3, WR_HI T4, WR_LO T5, FINISH T6.
- Each wait cycle adds one cycle to its state.
- `mem_req` stays high across back-to-back accesses (RD_LO to RD_HI, WR_HI to WR_LO); address and data change the cycle after the ack.
- The earliest accepted new start is the IDLE cycle after FINISH, which is T4 or T7.

## Test plan
- NZ start, flags=0x00, pc_in=0x1000, sp_in=0x8000, rdata 0x34 then 0x12, zero wait.
  - Reads at 0x1000 and 0x1001.
  - Writes 0x10 at 0x7FFF, then 0x02 at 0x7FFE.
  - `pc_next`=0x1234 and `sp_next`=0x7FFE at T6.
- Z start, flags=0x00: two reads only; `pc_next`=0x1002, no `sp_load`, `done` at T3.
- M start, flags=0x80, sp_in=0x0000, pc_in=0xFFFF.
  - Reads at 0xFFFF and 0x0000.
  - Writes 0x00 at 0xFFFF and 0x01 at 0xFFFE; `sp_next`=0xFFFE.
- PE start, flags=0x04, 3 wait cycles on every access.
  - Bus signals stay stable through the waits.
  - `done` lands at T18.
- Strobes k=0 and k=3 together: `start_err` pulses and no `mem_req`. Then a strobe during RD_HI is ignored.
- Assert `notReset` low during WR_HI: all outputs 0 immediately; no `pc_load` or `sp_load`. The next start behaves normally.

Source files
------------

// File: rtl/icallccnn_sequencer.sv
// Execution sequencer for Z80 CALL cc,nn: fetches nn, evaluates cc, pushes PC+2
// and redirects PC when taken. All bus and register-file outputs are registered.
module icallccnn_sequencer (
    input  logic        CLK,
    input  logic        notReset,
    input  logic        P2_Set_ICALLccnn_0_0,
    input  logic        P2_Set_ICALLccnn_1_0,
    input  logic        P2_Set_ICALLccnn_2_0,
    input  logic        P2_Set_ICALLccnn_3_0,
    input  logic        P2_Set_ICALLccnn_4_0,
    input  logic        P2_Set_ICALLccnn_5_0,
    input  logic        P2_Set_ICALLccnn_6_0,
    input  logic        P2_Set_ICALLccnn_7_0,
    input  logic [7:0]  flags,
    input  logic [15:0] pc_in,
    input  logic [15:0] sp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        pc_load,
    output logic [15:0] pc_next,
    output logic        sp_load,
    output logic [15:0] sp_next,
    output logic        done,
    output logic        start_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_EVAL, S_WR_HI, S_WR_LO, S_FINISH
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q, sp_q, nn_q;
    logic        cond_q;
    logic        mem_req_q, mem_we_q, pc_load_q, sp_load_q, done_q, start_err_q;
    logic [15:0] mem_addr_q, pc_next_q, sp_next_q;
    logic [7:0]  mem_wdata_q;

    logic [7:0]  strobe_d, cond_vec_d;
    logic        one_hot_d, multi_d, cond_d;
    logic [15:0] ret_d;

    assign strobe_d = {P2_Set_ICALLccnn_7_0, P2_Set_ICALLccnn_6_0,
                       P2_Set_ICALLccnn_5_0, P2_Set_ICALLccnn_4_0,
                       P2_Set_ICALLccnn_3_0, P2_Set_ICALLccnn_2_0,
                       P2_Set_ICALLccnn_1_0, P2_Set_ICALLccnn_0_0};

    // Bit k holds the truth of condition k: NZ,Z,NC,C,PO,PE,P,M.
    assign cond_vec_d = {flags[7], ~flags[7], flags[2], ~flags[2],
                         flags[0], ~flags[0], flags[6], ~flags[6]};

    assign one_hot_d = (strobe_d != 8'd0) && ((strobe_d & (strobe_d - 8'd1)) == 8'd0);
    assign multi_d   = (strobe_d != 8'd0) && !one_hot_d;
    assign cond_d    = |(strobe_d & cond_vec_d);
    assign ret_d     = pc_q + 16'd2;

    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            state_q     <= S_IDLE;
            pc_q        <= 16'd0;
            sp_q        <= 16'd0;
            nn_q        <= 16'd0;
            cond_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            pc_load_q   <= 1'b0;
            pc_next_q   <= 16'd0;
            sp_load_q   <= 1'b0;
            sp_next_q   <= 16'd0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            pc_load_q   <= 1'b0;
            sp_load_q   <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (one_hot_d) begin
                        pc_q       <= pc_in;
                        sp_q       <= sp_in;
                        cond_q     <= cond_d;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_in;
                        state_q    <= S_RD_LO;
                    end else if (multi_d) begin
                        start_err_q <= 1'b1;
                    end
                end
                S_RD_LO: begin
                    if (mem_ack) begin
                        nn_q[7:0]  <= mem_rdata;
                        mem_addr_q <= pc_q + 16'd1;
                        state_q    <= S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    if (mem_ack) begin
                        nn_q[15:8] <= mem_rdata;
                        mem_req_q  <= 1'b0;
                        if (cond_q) begin
                            state_q <= S_EVAL;
                        end else begin
                            done_q    <= 1'b1;
                            pc_load_q <= 1'b1;
                            pc_next_q <= ret_d;
                            state_q   <= S_FINISH;
                        end
                    end
                end
                S_EVAL: begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= sp_q - 16'd1;
                    mem_wdata_q <= ret_d[15:8];
                    state_q     <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (mem_ack) begin
                        mem_addr_q  <= sp_q - 16'd2;
                        mem_wdata_q <= ret_d[7:0];
                        state_q     <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        pc_load_q <= 1'b1;
                        pc_next_q <= nn_q;
                        sp_load_q <= 1'b1;
                        sp_next_q <= sp_q - 16'd2;
                        state_q   <= S_FINISH;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc_load   = pc_load_q;
    assign pc_next   = pc_next_q;
    assign sp_load   = sp_load_q;
    assign sp_next   = sp_next_q;
    assign done      = done_q;
    assign start_err = start_err_q;

endmodule
